spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
Multi-byte transaction sequencer that sits directly upstream of the team's byte-level SPI master engine. It accepts a command (target slave, byte count), drains TX bytes from an internal TX FIFO into the engine one byte at a time, and collects each received byte into an internal RX FIFO. Host logic sees a command port, streaming TX/RX FIFO ports, and done/abort status. The engine's per-byte handshake (DV pulse, TX-ready, RX-DV) is hidden from the host.

Parameters:
NUM_SLAVES, 4, number of chip selects on the downstream engine; slave id width is $clog2(NUM_SLAVES)
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; must be a power of 2, minimum 2

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Cmd_Valid  in  1  command strobe; accepted when o_Cmd_Ready=1
i_Cmd_Slave  in  $clog2(NUM_SLAVES)  target slave index
i_Cmd_Len  in  8  bytes to transfer, 0..255
o_Cmd_Ready  out  1  high only in IDLE
i_TX_Data  in  8  TX FIFO write data
i_TX_Valid  in  1  TX FIFO write strobe
o_TX_Ready  out  1  TX FIFO not full
o_RX_Data  out  8  RX FIFO head (show-ahead)
o_RX_Valid  out  1  RX FIFO not empty
i_RX_Ready  in  1  RX FIFO pop when o_RX_Valid=1
i_Abort  in  1  synchronous abort request
o_Busy  out  1  state != IDLE
o_Done  out  1  one-cycle pulse at end of a command
o_Aborted  out  1  qualifies o_Done; 1 = command ended by abort
o_Byte_TX_Byte  out  8  byte presented to the engine
o_Byte_TX_DV  out  1  one-cycle launch pulse to the engine
o_Byte_Slave_Select  out  $clog2(NUM_SLAVES)  slave index to the engine, held for the whole command
i_Byte_TX_Ready  in  1  engine idle
i_Byte_RX_DV  in  1  engine received-byte pulse
i_Byte_RX_Byte  in  8  engine received byte

Behaviour:
- Reset (async, i_Rst_L=0): state IDLE; both FIFOs empty; o_Cmd_Ready=1; o_TX_Ready=1; o_RX_Valid=0; o_Busy, o_Done, o_Aborted, o_Byte_TX_DV=0; o_Byte_TX_Byte=0; o_Byte_Slave_Select=0; remaining count=0. Reset mid-transfer discards everything. The engine's own reset is expected to be shared.
- FIFOs: synchronous, registered count. Write when full is ignored. Pop when empty is ignored. Simultaneous push and pop is legal at any fill level, including full (count unchanged) and empty.
- TX FIFO writes are accepted in every state, including IDLE, so data can be preloaded.
- States: IDLE, LOAD, LAUNCH, WAIT_RX, WAIT_RDY, FINISH.
- IDLE: on i_Cmd_Valid, latch slave into o_Byte_Slave_Select and remaining=i_Cmd_Len.
  - i_Cmd_Len=0: go to FINISH.
  - Otherwise: go to LOAD.
- LOAD: advance to LAUNCH when all of the following hold: TX FIFO not empty, RX FIFO count < FIFO_DEPTH, i_Byte_TX_Ready=1. Otherwise wait indefinitely; there is no timeout.
- LAUNCH (1 cycle):
  - Pop the TX FIFO head into o_Byte_TX_Byte.
  - Drive o_Byte_TX_DV=1 for exactly this cycle.
  - Decrement remaining.
  - Go to WAIT_RX.
- WAIT_RX: on i_Byte_RX_DV, push i_Byte_RX_Byte into the RX FIFO. Space is guaranteed by the LOAD check. Go to WAIT_RDY.
- WAIT_RDY: on i_Byte_TX_Ready=1, go to LOAD if remaining>0, else to FINISH.
- FINISH (1 cycle): o_Done=1, then return to IDLE.
- Latency: a command accepted in cycle N with TX data present and the engine ready gives LOAD in N+1 and o_Byte_TX_DV in N+2. i_Cmd_Len=0 gives o_Done in N+2.
- i_Byte_RX_DV outside WAIT_RX is ignored; it is not pushed into the RX FIFO.
- Abort: i_Abort in IDLE is ignored. In any other state it sets an abort flag.
  - In LOAD: go to FINISH next cycle.
  - In WAIT_RX or WAIT_RDY: the in-flight byte completes and its RX byte is pushed, then go to FINISH instead of LOAD.
  - An abort that coincides with LAUNCH still launches that byte.
  - On abort, FINISH flushes the TX FIFO and pulses o_Done with o_Aborted=1.
  - o_Aborted=0 whenever o_Done=1 on normal completion. o_Aborted=0 at all other times.
- o_Byte_Slave_Select is constant from command accept until the next command accept.

Test Plan:
- Preload 0xA5,0x3C; command slave=2, len=2 → o_Byte_TX_DV pulses twice, o_Byte_TX_Byte=0xA5 then 0x3C, o_Byte_Slave_Select=2. Engine model returns 0x11,0x22; RX FIFO yields 0x11,0x22; o_Done=1 and o_Aborted=0 once.
- Command len=0 in cycle N → no o_Byte_TX_DV; o_Done in N+2; o_Busy high for N+1..N+2.
- Command len=3 with only 1 byte preloaded → one launch, then the sequencer stalls in LOAD. Write 2 more bytes 20 cycles later → two further launches and o_Done.
- FIFO_DEPTH=8, command len=10, i_RX_Ready=0 → exactly 8 launches, then stall. Pop 2 → remaining 2 launch; RX count returns to 8; o_Done.
- 5 bytes preloaded, len=5; assert i_Abort during the 2nd WAIT_RX → the 2nd RX byte is pushed, no 3rd launch, TX FIFO empty after FINISH, o_Done=1 with o_Aborted=1.
- Deassert i_Rst_L during WAIT_RX → all outputs take reset values immediately; a new len=1 command after release completes normally.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transaction sequencer: drains a TX FIFO into a byte-level SPI
// engine one byte at a time and collects the returned bytes into an RX FIFO.
module spi_xfer_sequencer #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Cmd_Valid,
  input  logic [SW-1:0] i_Cmd_Slave,
  input  logic [7:0]    i_Cmd_Len,
  output logic          o_Cmd_Ready,
  input  logic [7:0]    i_TX_Data,
  input  logic          i_TX_Valid,
  output logic          o_TX_Ready,
  output logic [7:0]    o_RX_Data,
  output logic          o_RX_Valid,
  input  logic          i_RX_Ready,
  input  logic          i_Abort,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_Aborted,
  output logic [7:0]    o_Byte_TX_Byte,
  output logic          o_Byte_TX_DV,
  output logic [SW-1:0] o_Byte_Slave_Select,
  input  logic          i_Byte_TX_Ready,
  input  logic          i_Byte_RX_DV,
  input  logic [7:0]    i_Byte_RX_Byte
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_WAIT_RX, S_WAIT_RDY, S_FINISH
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    rem_q, rem_nx;
  logic [SW-1:0] sel_nx;
  logic          abort_q, abort_nx, abort_in;
  logic          tx_pop_req, tx_flush, rx_push_req;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_pop   = tx_pop_req && !tx_empty;
  assign tx_push  = i_TX_Valid && (!tx_full || tx_pop) && !tx_flush;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_rd  <= tx_wr;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (tx_push) tx_mem[tx_wr] <= i_TX_Data;
  end

  // RX FIFO, show-ahead head
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = i_RX_Ready && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (rx_push) rx_mem[rx_wr] <= i_Byte_RX_Byte;
  end

  assign o_TX_Ready = !tx_full;
  assign o_RX_Valid = !rx_empty;
  assign o_RX_Data  = rx_mem[rx_rd];

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state and per-state actions
  always_comb begin
    state_nx    = state;
    rem_nx      = rem_q;
    sel_nx      = o_Byte_Slave_Select;
    abort_nx    = abort_q;
    tx_pop_req  = 1'b0;
    tx_flush    = 1'b0;
    rx_push_req = 1'b0;
    abort_in    = i_Abort && (state != S_IDLE) && (state != S_FINISH);
    if (abort_in) abort_nx = 1'b1;
    case (state)
      S_IDLE: begin
        if (i_Cmd_Valid && o_Cmd_Ready) begin
          sel_nx   = i_Cmd_Slave;
          rem_nx   = i_Cmd_Len;
          state_nx = (i_Cmd_Len == 8'd0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_q || abort_in)
          state_nx = S_FINISH;
        else if (!tx_empty && !rx_full && i_Byte_TX_Ready)
          state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        tx_pop_req = 1'b1;
        rem_nx     = rem_q - 8'd1;
        state_nx   = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (i_Byte_RX_DV) begin
          rx_push_req = 1'b1;
          state_nx    = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (i_Byte_TX_Ready)
          state_nx = (abort_q || abort_in || rem_q == 8'd0) ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        tx_flush = abort_q;
        abort_nx = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered datapath and host/engine outputs; busy spans the done cycle
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rem_q               <= '0;
      abort_q             <= 1'b0;
      o_Byte_Slave_Select <= '0;
      o_Busy              <= 1'b0;
      o_Cmd_Ready         <= 1'b1;
      o_Done              <= 1'b0;
      o_Aborted           <= 1'b0;
      o_Byte_TX_DV        <= 1'b0;
      o_Byte_TX_Byte      <= '0;
    end else begin
      rem_q               <= rem_nx;
      abort_q             <= abort_nx;
      o_Byte_Slave_Select <= sel_nx;
      o_Busy              <= (state_nx != S_IDLE) || (state == S_FINISH);
      o_Cmd_Ready         <= (state_nx == S_IDLE) && (state != S_FINISH);
      o_Done              <= (state == S_FINISH);
      o_Aborted           <= (state == S_FINISH) && abort_q;
      o_Byte_TX_DV        <= (state_nx == S_LAUNCH);
      if (state_nx == S_LAUNCH) o_Byte_TX_Byte <= tx_mem[tx_rd];
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer with a queue-based scoreboard and a
// behavioural byte-engine model.
module tb_spi_xfer_sequencer;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_slave;
  logic [7:0] cmd_len;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       abort, busy, done, aborted;
  logic [7:0] b_tx_byte, b_rx_byte;
  logic       b_tx_dv, b_tx_ready, b_rx_dv;
  logic [1:0] b_sel;

  spi_xfer_sequencer #(.NUM_SLAVES(4), .FIFO_DEPTH(8)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Cmd_Valid(cmd_valid), .i_Cmd_Slave(cmd_slave), .i_Cmd_Len(cmd_len),
    .o_Cmd_Ready(cmd_ready),
    .i_TX_Data(tx_data), .i_TX_Valid(tx_valid), .o_TX_Ready(tx_ready),
    .o_RX_Data(rx_data), .o_RX_Valid(rx_valid), .i_RX_Ready(rx_ready),
    .i_Abort(abort), .o_Busy(busy), .o_Done(done), .o_Aborted(aborted),
    .o_Byte_TX_Byte(b_tx_byte), .o_Byte_TX_DV(b_tx_dv),
    .o_Byte_Slave_Select(b_sel),
    .i_Byte_TX_Ready(b_tx_ready), .i_Byte_RX_DV(b_rx_dv),
    .i_Byte_RX_Byte(b_rx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: bytes accepted into TX, bytes the engine returned, current slave
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] fixed_rx[$];
  logic [1:0] exp_sel = 2'd0;
  int launch_cnt = 0, done_cnt = 0;
  logic last_aborted = 1'b0;
  logic eng_hold = 1'b0;
  int spur_req = 0;
  int s_l, s_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch / completion monitor, sampled mid-cycle
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b_tx_dv) begin
          launch_cnt++;
          if (exp_tx.size() == 0) check("tx_underflow", 1, 0);
          else begin
            b = exp_tx.pop_front();
            check("launch_byte", b_tx_byte, b);
          end
          check("launch_sel", b_sel, exp_sel);
        end
        if (done) begin
          done_cnt++;
          last_aborted = aborted;
          if (aborted) exp_tx.delete();
        end
      end
    end
  end

  // Byte engine: drops ready after a launch, returns a byte later, then recovers
  initial begin
    int eph, ewait, eng_seen, spur_done;
    eph = 0; ewait = 0; eng_seen = 0; spur_done = 0;
    b_tx_ready = 1'b1; b_rx_dv = 1'b0; b_rx_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      b_rx_dv = 1'b0;
      if (!rst_n) begin
        eph = 0; b_tx_ready = 1'b1; eng_seen = launch_cnt;
      end else begin
        case (eph)
          0: begin
            if (eng_seen != launch_cnt) begin
              eng_seen = launch_cnt; b_tx_ready = 1'b0;
              ewait = $urandom_range(0, 3); eph = 1;
            end else if (spur_done != spur_req) begin
              spur_done = spur_req; b_rx_dv = 1'b1; b_rx_byte = 8'h5A;
            end else b_tx_ready = !eng_hold;
          end
          1: begin
            if (ewait == 0) begin
              if (fixed_rx.size() != 0) b_rx_byte = fixed_rx.pop_front();
              else b_rx_byte = 8'($urandom);
              b_rx_dv = 1'b1;
              exp_rx.push_back(b_rx_byte);
              ewait = $urandom_range(0, 3); eph = 2;
            end else ewait--;
          end
          default: begin
            if (ewait == 0) begin b_tx_ready = !eng_hold; eph = 0; end
            else ewait--;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    if (tx_ready || b_tx_dv) exp_tx.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    check("rx_valid", rx_valid, exp_rx.size() != 0);
    if (exp_rx.size() != 0) check("rx_data", rx_data, exp_rx.pop_front());
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] slave, input logic [7:0] len);
    int i;
    for (i = 0; i < 100 && !cmd_ready; i++) tick();
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_slave = slave; cmd_len = len; exp_sel = slave;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int start;
    start = done_cnt;
    for (int i = 0; i < max && done_cnt == start; i++) tick();
    if (done_cnt == start) check("done_timeout", 0, 1);
  endtask

  task automatic wait_launches(input int target, input int max);
    for (int i = 0; i < max && launch_cnt < target; i++) tick();
    if (launch_cnt < target) check("launch_timeout", launch_cnt, target);
  endtask

  task automatic mark();
    s_l = launch_cnt; s_d = done_cnt;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_slave = 2'd0; cmd_len = 8'd0;
    tx_data = 8'd0; tx_valid = 1'b0; rx_ready = 1'b0; abort = 1'b0;
    #22;
    check("rst_cmd_ready", cmd_ready, 1); check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);  check("rst_busy", busy, 0);
    check("rst_done", done, 0);          check("rst_aborted", aborted, 0);
    check("rst_dv", b_tx_dv, 0);         check("rst_tx_byte", b_tx_byte, 0);
    check("rst_sel", b_sel, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_cycles(2);

    // Basic two-byte transfer with exact launch latency
    fixed_rx.push_back(8'h11); fixed_rx.push_back(8'h22);
    push_tx(8'hA5); push_tx(8'h3C);
    mark();
    check("t1_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_slave = 2'd2; cmd_len = 8'd2; exp_sel = 2'd2;
    tick(); cmd_valid = 1'b0;
    check("t1_dv_n1", b_tx_dv, 0); check("t1_busy_n1", busy, 1);
    tick();
    check("t1_dv_n2", b_tx_dv, 1); check("t1_byte_n2", b_tx_byte, 8'hA5);
    wait_done(200);
    check("t1_launches", launch_cnt - s_l, 2); check("t1_dones", done_cnt - s_d, 1);
    check("t1_aborted", last_aborted, 0);      check("t1_sel", b_sel, 2);
    check("t1_rx_head", rx_data, 8'h11);
    pop_rx(); pop_rx();

    // Zero-length command timing
    mark();
    check("t2_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_len = 8'd0; exp_sel = 2'd1;
    tick(); cmd_valid = 1'b0;
    check("t2_busy_n1", busy, 1); check("t2_done_n1", done, 0);
    tick();
    check("t2_busy_n2", busy, 1); check("t2_done_n2", done, 1);
    check("t2_aborted_n2", aborted, 0);
    tick();
    check("t2_busy_n3", busy, 0); check("t2_done_n3", done, 0);
    check("t2_ready_n3", cmd_ready, 1); check("t2_launches", launch_cnt - s_l, 0);

    // Stall in LOAD on empty TX FIFO
    mark();
    push_tx(8'($urandom));
    send_cmd(2'd1, 8'd3);
    wait_cycles(20);
    check("t3_launch_stall", launch_cnt - s_l, 1); check("t3_busy", busy, 1);
    check("t3_no_done", done_cnt - s_d, 0);
    push_tx(8'($urandom)); push_tx(8'($urandom));
    wait_done(200);
    check("t3_launches", launch_cnt - s_l, 3);
    pop_rx(); pop_rx(); pop_rx();

    // RX FIFO back-pressure: full RX stops launches
    mark();
    for (int k = 0; k < 8; k++) push_tx(8'($urandom));
    check("t4_tx_full", tx_ready, 0);
    send_cmd(2'd3, 8'd10);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 100 && !tx_ready; i++) tick();
      push_tx(8'($urandom));
    end
    wait_cycles(60);
    check("t4_launch_stall", launch_cnt - s_l, 8); check("t4_busy", busy, 1);
    pop_rx(); pop_rx();
    wait_done(200);
    check("t4_launches", launch_cnt - s_l, 10);
    for (int k = 0; k < 8; k++) pop_rx();
    check("t4_rx_empty", rx_valid, 0);

    // Abort during the second WAIT_RX
    mark();
    for (int k = 0; k < 5; k++) push_tx(8'($urandom));
    send_cmd(2'd0, 8'd5);
    wait_launches(s_l + 2, 200);
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done(200);
    check("t5_launches", launch_cnt - s_l, 2); check("t5_aborted", last_aborted, 1);
    pop_rx(); pop_rx();
    check("t5_rx_empty", rx_valid, 0);
    for (int k = 0; k < 7; k++) push_tx(8'($urandom));
    check("t5_tx_flushed", tx_ready, 1);
    push_tx(8'($urandom));
    check("t5_tx_full", tx_ready, 0);
    push_tx(8'hEE);

    // Abort while stalled in LOAD flushes the TX FIFO
    mark();
    eng_hold = 1'b1;
    send_cmd(2'd1, 8'd3);
    wait_cycles(10);
    check("t5b_stall", launch_cnt - s_l, 0); check("t5b_busy", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done(50);
    eng_hold = 1'b0;
    check("t5b_aborted", last_aborted, 1); check("t5b_tx_ready", tx_ready, 1);
    push_tx(8'hC3);
    send_cmd(2'd2, 8'd1);
    wait_done(200);
    check("t5b_after", launch_cnt - s_l, 1); check("t5b_after_ab", last_aborted, 0);
    pop_rx();

    // Stray engine RX pulse while idle is dropped
    spur_req++;
    wait_cycles(4);
    check("t6_rx_ignored", rx_valid, 0);

    // Reset in the middle of WAIT_RX
    mark();
    push_tx(8'($urandom));
    send_cmd(2'd3, 8'd1);
    wait_launches(s_l + 1, 100);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t7_busy", busy, 0);        check("t7_dv", b_tx_dv, 0);
    check("t7_cmd_ready", cmd_ready, 1); check("t7_tx_ready", tx_ready, 1);
    check("t7_rx_valid", rx_valid, 0);   check("t7_sel", b_sel, 0);
    check("t7_tx_byte", b_tx_byte, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    exp_tx.delete(); exp_rx.delete(); exp_sel = 2'd0;
    wait_cycles(2);
    mark();
    push_tx(8'($urandom));
    send_cmd(2'd2, 8'd1);
    wait_done(200);
    check("t7_after", launch_cnt - s_l, 1); check("t7_after_ab", last_aborted, 0);
    pop_rx();

    // Randomized commands with concurrent TX pushes and RX pops
    for (int it = 0; it < 8; it++) begin
      int len, pre, pushed, cyc;
      len = $urandom_range(0, 12);
      pre = (len < 8) ? $urandom_range(0, len) : $urandom_range(0, 8);
      for (int k = 0; k < pre; k++) push_tx(8'($urandom));
      pushed = pre;
      mark();
      send_cmd(2'($urandom), 8'(len));
      cyc = 0;
      while (done_cnt == s_d && cyc < 600) begin
        tx_valid = 1'b0; rx_ready = 1'b0;
        if (pushed < len && tx_ready && $urandom_range(0, 1) == 1) begin
          tx_data = 8'($urandom); tx_valid = 1'b1;
          exp_tx.push_back(tx_data); pushed++;
        end
        if (rx_valid && $urandom_range(0, 2) == 0) begin
          if (exp_rx.size() == 0) check("rnd_rx_extra", 1, 0);
          else check("rnd_rx_data", rx_data, exp_rx.pop_front());
          rx_ready = 1'b1;
        end
        tick(); cyc++;
      end
      tx_valid = 1'b0; rx_ready = 1'b0;
      check("rnd_done", done_cnt - s_d, 1);
      check("rnd_launches", launch_cnt - s_l, len);
      check("rnd_aborted", last_aborted, 0);
      for (int k = 0; k < 20 && exp_rx.size() != 0; k++) pop_rx();
    end

    check("end_tx_model", exp_tx.size(), 0);
    check("end_rx_model", exp_rx.size(), 0);
    check("end_rx_valid", rx_valid, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
